// File: rtl/keypad_pkg.sv
// Shared types and key codes for the keypad consumer stage.
// Imported by the operand-capture FSM and its bench.
package keypad_pkg;

  typedef enum logic [1:0] {
    CAP_A = 2'b00,
    CAP_B = 2'b01,
    LISTO = 2'b10
  } estado_cap_t;

  localparam logic [3:0] TECLA_ENTER      = 4'hA;
  localparam logic [3:0] TECLA_BORRAR     = 4'hB;
  localparam logic [3:0] TECLA_MAX_DIGITO = 4'h9;

  function automatic logic es_digito(input logic [3:0] codigo);
    return codigo <= TECLA_MAX_DIGITO;
  endfunction

endpackage

// File: rtl/captura_operandos_if.sv
// Key input / operand output bundle between the keypad stage, the capture
// block and the arithmetic consumer.
interface captura_operandos_if #(
  parameter int N_DIGITOS = 3
);
  logic                     data_available_i;
  logic [3:0]               dato_i;
  logic                     ack_i;
  logic [4*N_DIGITOS-1:0]   operando_a_o;
  logic [4*N_DIGITOS-1:0]   operando_b_o;
  logic                     operandos_validos_o;
  logic [1:0]               estado_o;
  logic                     lleno_o;
  logic                     tecla_pulso_o;

  modport master (
    output data_available_i, dato_i, ack_i,
    input  operando_a_o, operando_b_o, operandos_validos_o,
           estado_o, lleno_o, tecla_pulso_o
  );

  modport slave (
    input  data_available_i, dato_i, ack_i,
    output operando_a_o, operando_b_o, operandos_validos_o,
           estado_o, lleno_o, tecla_pulso_o
  );
endinterface

// File: rtl/detector_flanco.sv
// Single-bit rising-edge detector; the history reset value decides whether
// a level already high when reset releases counts as an edge.
module detector_flanco #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic flanco
);

  logic hist;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= RESET_VAL;
    else        hist <= d;
  end

  assign flanco = d & ~hist;

endmodule

// File: rtl/captura_operandos.sv
// Builds two BCD operands from keypad events and holds them, flagged valid,
// until the consumer acknowledges them.
module captura_operandos
  import keypad_pkg::*;
#(
  parameter int N_DIGITOS = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  captura_operandos_if.slave  bus
);

  localparam int W  = 4 * N_DIGITOS;
  localparam int CW = $clog2(N_DIGITOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITOS);
  localparam logic [CW-1:0] CNT_ULT = CW'(N_DIGITOS - 1);
  localparam logic [CW-1:0] UNO     = CW'(1);

  estado_cap_t   estado;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [CW-1:0] cuenta;
  logic          lleno;
  logic          validos;
  logic          pulso;

  logic tecla_nueva;
  logic ack_listo;
  logic borrar;
  logic en_captura;
  logic es_dig;
  logic es_enter;

  // History resets high so a key held through reset release is not taken.
  detector_flanco #(.RESET_VAL(1'b1)) u_flanco (
    .clk    (clk_i),
    .rst_n  (reset_i),
    .d      (bus.data_available_i),
    .flanco (tecla_nueva)
  );

  assign ack_listo  = (estado == LISTO) && bus.ack_i;
  assign borrar     = tecla_nueva && (bus.dato_i == TECLA_BORRAR);
  assign en_captura = (estado != LISTO);
  assign es_dig     = es_digito(bus.dato_i);
  assign es_enter   = (bus.dato_i == TECLA_ENTER);

  // NOTE: the operand registers sit on the async reset too, so no partial
  // operand survives a reset pulse in the middle of a capture.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      estado  <= CAP_A;
      op_a    <= '0;
      op_b    <= '0;
      cuenta  <= '0;
      lleno   <= 1'b0;
      validos <= 1'b0;
      pulso   <= 1'b0;
    end else begin
      pulso <= 1'b0;
      // ack in LISTO and CLEAR share one end state; ack swallows any key.
      if (ack_listo || borrar) begin
        estado  <= CAP_A;
        op_a    <= '0;
        op_b    <= '0;
        cuenta  <= '0;
        lleno   <= 1'b0;
        validos <= 1'b0;
        pulso   <= !ack_listo;
      end else if (tecla_nueva && en_captura && es_dig) begin
        pulso <= 1'b1;
        if (cuenta != CNT_MAX) begin
          if (estado == CAP_A) op_a <= {op_a[W-5:0], bus.dato_i};
          else                 op_b <= {op_b[W-5:0], bus.dato_i};
          cuenta <= cuenta + UNO;
          lleno  <= (cuenta == CNT_ULT);
        end
      end else if (tecla_nueva && en_captura && es_enter && cuenta != '0) begin
        pulso  <= 1'b1;
        cuenta <= '0;
        lleno  <= 1'b0;
        if (estado == CAP_A) begin
          estado <= CAP_B;
        end else begin
          estado  <= LISTO;
          validos <= 1'b1;
        end
      end
    end
  end

  assign bus.operando_a_o        = op_a;
  assign bus.operando_b_o        = op_b;
  assign bus.operandos_validos_o = validos;
  assign bus.estado_o            = estado;
  assign bus.lleno_o             = lleno;
  assign bus.tecla_pulso_o       = pulso;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed key sequences plus random traffic,
// compared every cycle against a digit-list model of the operand entry.
module tb_captura_operandos;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  captura_operandos_if #(.N_DIGITOS(N)) bus ();

  captura_operandos #(.N_DIGITOS(N)) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  // Model: a state number and the list of digits typed into each operand.
  int m_state;
  int qa[$];
  int qb[$];
  bit m_prev;
  bit m_pulse;

  function automatic int valor(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    qa.delete();
    qb.delete();
    m_prev  = 1'b1;
    m_pulse = 1'b0;
  endtask

  task automatic model_clear();
    m_state = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input bit da, input int code, input bit ack);
    bit ev;
    int cur;
    ev      = da && !m_prev;
    m_prev  = da;
    m_pulse = 1'b0;
    cur     = (m_state == 0) ? qa.size() : qb.size();
    if (m_state == 2 && ack) begin
      model_clear();
    end else if (ev) begin
      if (code == 11) begin
        model_clear();
        m_pulse = 1'b1;
      end else if (code <= 9 && m_state != 2) begin
        m_pulse = 1'b1;
        if (cur < N) begin
          if (m_state == 0) qa.push_back(code);
          else              qb.push_back(code);
        end
      end else if (code == 10 && m_state != 2 && cur > 0) begin
        m_pulse = 1'b1;
        m_state = m_state + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    int cur;
    cur = (m_state == 0) ? qa.size() : qb.size();
    check("estado",   32'(bus.estado_o),            32'(m_state));
    check("op_a",     32'(bus.operando_a_o),        32'(valor(qa)));
    check("op_b",     32'(bus.operando_b_o),        32'(valor(qb)));
    check("validos",  32'(bus.operandos_validos_o), 32'(m_state == 2));
    check("lleno",    32'(bus.lleno_o),             32'(m_state != 2 && cur == N));
    check("pulso",    32'(bus.tecla_pulso_o),       32'(m_pulse));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.data_available_i, int'(bus.dato_i), bus.ack_i);
    #1;
    if (bus.tecla_pulso_o) pulses++;
    check_all();
  endtask

  task automatic press(input logic [3:0] code, input int hold = 5, input int gap = 3);
    bus.data_available_i = 1'b1;
    bus.dato_i = code;
    repeat (hold) tick();
    bus.data_available_i = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    bus.data_available_i = 1'b0;
    bus.dato_i = 4'h0;
    bus.ack_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("reset_estado", 32'(bus.estado_o), 32'h0);
    check("reset_pulso",  32'(bus.tecla_pulso_o), 32'h0);
    tick();

    // A=123, B=45, then ENTER into LISTO.
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5); press(4'hA);
    check("t1_op_a",   32'(bus.operando_a_o), 32'h123);
    check("t1_op_b",   32'(bus.operando_b_o), 32'h045);
    check("t1_valid",  32'(bus.operandos_validos_o), 32'h1);
    check("t1_estado", 32'(bus.estado_o), 32'h2);

    // LISTO ignores a long digit press.
    pulses = 0;
    press(4'h5, 20, 3);
    check("listo_estado", 32'(bus.estado_o), 32'h2);
    check("listo_op_a",   32'(bus.operando_a_o), 32'h123);
    check("listo_pulses", 32'(pulses), 32'h0);

    // ack together with a key edge: ack wins, key dropped.
    bus.ack_i = 1'b1;
    bus.data_available_i = 1'b1;
    bus.dato_i = 4'h3;
    tick();
    bus.ack_i = 1'b0;
    check("ack_estado", 32'(bus.estado_o), 32'h0);
    check("ack_op_a",   32'(bus.operando_a_o), 32'h0);
    check("ack_op_b",   32'(bus.operando_b_o), 32'h0);
    check("ack_pulso",  32'(bus.tecla_pulso_o), 32'h0);
    repeat (3) tick();
    bus.data_available_i = 1'b0;
    repeat (3) tick();

    // Saturation: the fourth digit is discarded but still pulses.
    pulses = 0;
    press(4'h7); press(4'h8); press(4'h9);
    check("sat_lleno", 32'(bus.lleno_o), 32'h1);
    press(4'h6);
    check("sat_op_a",   32'(bus.operando_a_o), 32'h789);
    check("sat_pulses", 32'(pulses), 32'h4);
    press(4'hA);
    check("sat_estado", 32'(bus.estado_o), 32'h1);
    check("sat_lleno_b", 32'(bus.lleno_o), 32'h0);
    press(4'hB);

    // Empty ENTER and an unused code do nothing.
    pulses = 0;
    press(4'hA); press(4'hE);
    check("vacio_estado", 32'(bus.estado_o), 32'h0);
    check("vacio_pulses", 32'(pulses), 32'h0);
    check("vacio_op_a",   32'(bus.operando_a_o), 32'h0);

    // CLEAR in the middle of operand B.
    press(4'h0); press(4'h1); press(4'h2);
    check("clr_op_a", 32'(bus.operando_a_o), 32'h012);
    press(4'hA); press(4'h3); press(4'h4);
    check("clr_op_b", 32'(bus.operando_b_o), 32'h034);
    press(4'hB);
    check("clr_estado", 32'(bus.estado_o), 32'h0);
    check("clr_op_a0",  32'(bus.operando_a_o), 32'h0);
    check("clr_op_b0",  32'(bus.operando_b_o), 32'h0);
    check("clr_lleno",  32'(bus.lleno_o), 32'h0);

    // Key 9 held across reset release is not captured.
    @(negedge clk);
    bus.data_available_i = 1'b1;
    bus.dato_i = 4'h9;
    reset_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (5) tick();
    check("hold_op_a",   32'(bus.operando_a_o), 32'h0);
    check("hold_pulses", 32'(pulses), 32'h0);
    bus.data_available_i = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while B is being typed.
    press(4'h1); press(4'hA); press(4'h2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("ares_estado", 32'(bus.estado_o), 32'h0);
    check("ares_op_a",   32'(bus.operando_a_o), 32'h0);
    check("ares_op_b",   32'(bus.operando_b_o), 32'h0);
    check("ares_lleno",  32'(bus.lleno_o), 32'h0);
    check("ares_valid",  32'(bus.operandos_validos_o), 32'h0);
    check("ares_pulso",  32'(bus.tecla_pulso_o), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Random key traffic with random ack levels.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (bus.data_available_i) begin
        if ($urandom_range(0, 2) == 0) bus.data_available_i = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        r = int'($urandom_range(0, 19));
        bus.data_available_i = 1'b1;
        if (r < 11)      bus.dato_i = 4'(r % 10);
        else if (r < 15) bus.dato_i = 4'hA;
        else if (r < 16) bus.dato_i = 4'hB;
        else             bus.dato_i = 4'(12 + (r - 16));
      end
      bus.ack_i = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
